// File: rtl/pic_inta_sequencer_if.sv
// ============================================================================
// Module : pic_inta_sequencer_if
// Desc   : CPU-side and resolver-side signal bundle of the PIC INTA/EOI sequencer
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface pic_inta_sequencer_if;
  logic [7:0] resolved_irq;
  logic       inta;
  logic       icw2_wr;
  logic [7:0] icw2_data;
  logic       eoi_valid;
  logic [1:0] eoi_type;
  logic [2:0] eoi_level;
  logic       int_out;
  logic [7:0] isr;
  logic [2:0] priority_rotate;
  logic [7:0] clear_irr;
  logic [7:0] data_out;
  logic       data_out_en;

  modport master (
    output resolved_irq, inta, icw2_wr, icw2_data, eoi_valid, eoi_type, eoi_level,
    input  int_out, isr, priority_rotate, clear_irr, data_out, data_out_en
  );

  modport slave (
    input  resolved_irq, inta, icw2_wr, icw2_data, eoi_valid, eoi_type, eoi_level,
    output int_out, isr, priority_rotate, clear_irr, data_out, data_out_en
  );
endinterface

`default_nettype wire

// File: rtl/pic_inta_sequencer.sv
// ============================================================================
// Module : pic_inta_sequencer
// Desc   : Two-pulse INTA handshake, in-service register and EOI/rotation control
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pic_inta_sequencer #(
  parameter logic [7:0] RESET_BASE = 8'h08,
  parameter bit         AEOI       = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  pic_inta_sequencer_if.slave   bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACK1 = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] base_q, base_d;
  logic [2:0] level_q, level_d;
  logic       spurious_q, spurious_d;
  logic [7:0] isr_q, isr_d;
  logic [2:0] rot_q, rot_d;
  logic       int_q, int_d;
  logic [7:0] clr_q, clr_d;
  logic [7:0] dout_q, dout_d;
  logic       den_q, den_d;

  logic [7:0] eoi_clear;
  logic [7:0] aeoi_clear;
  logic [7:0] inta_set;
  logic       ns_found;
  logic [2:0] ns_level;
  logic [2:0] req_level;
  logic       unused_icw2_low;

  assign unused_icw2_low = ^bus.icw2_data[2:0];

  // Cyclic scan from the rotation point; iterating downward keeps the lowest offset.
  always_comb begin
    ns_found = 1'b0;
    ns_level = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (isr_q[rot_q + 3'(i)]) begin
        ns_found = 1'b1;
        ns_level = rot_q + 3'(i);
      end
    end
  end

  always_comb begin
    req_level = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (bus.resolved_irq[i]) req_level = 3'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    level_d    = level_q;
    spurious_d = spurious_q;
    rot_d      = rot_q;
    int_d      = 1'b0;
    clr_d      = 8'h00;
    dout_d     = dout_q;
    den_d      = 1'b0;
    eoi_clear  = 8'h00;
    aeoi_clear = 8'h00;
    inta_set   = 8'h00;

    case (state_q)
      IDLE: begin
        int_d = |bus.resolved_irq;
        if (bus.inta) begin
          int_d      = 1'b0;
          inta_set   = bus.resolved_irq;
          clr_d      = bus.resolved_irq;
          spurious_d = ~|bus.resolved_irq;
          level_d    = (|bus.resolved_irq) ? req_level : 3'd7;
          state_d    = ACK1;
        end
      end
      ACK1: begin
        if (bus.inta) begin
          dout_d  = {base_q, level_q};
          den_d   = 1'b1;
          if (AEOI && !spurious_q) aeoi_clear[level_q] = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.eoi_valid) begin
      case (bus.eoi_type)
        2'b00: if (ns_found) eoi_clear[ns_level] = 1'b1;
        2'b01: eoi_clear[bus.eoi_level] = 1'b1;
        2'b10: begin
          if (ns_found) begin
            eoi_clear[ns_level] = 1'b1;
            rot_d               = ns_level + 3'd1;
          end
        end
        default: rot_d = bus.eoi_level + 3'd1;
      endcase
    end

    // A same-cycle INTA set overrides an EOI clear of the same bit.
    isr_d = (isr_q & ~eoi_clear & ~aeoi_clear) | inta_set;

    if (bus.icw2_wr) base_d = bus.icw2_data[7:3];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      base_q     <= RESET_BASE[7:3];
      level_q    <= 3'd0;
      spurious_q <= 1'b0;
      isr_q      <= 8'h00;
      rot_q      <= 3'd0;
      int_q      <= 1'b0;
      clr_q      <= 8'h00;
      dout_q     <= 8'h00;
      den_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      level_q    <= level_d;
      spurious_q <= spurious_d;
      isr_q      <= isr_d;
      rot_q      <= rot_d;
      int_q      <= int_d;
      clr_q      <= clr_d;
      dout_q     <= dout_d;
      den_q      <= den_d;
    end
  end

  assign bus.int_out         = int_q;
  assign bus.isr             = isr_q;
  assign bus.priority_rotate = rot_q;
  assign bus.clear_irr       = clr_q;
  assign bus.data_out        = dout_q;
  assign bus.data_out_en     = den_q;

endmodule

`default_nettype wire
